fetcher: RTL

Instruction fetch stage sitting directly in front of the instruction cache. Holds the architectural fetch PC, probes the icache every cycle, and on a miss issues a fetch request to the memory controller and waits for the refill. Hit instructions (16-bit compressed or 32-bit) go to the instruction queue, one per cycle, each with its PC and predicted next PC. Flush redirects the PC.

---
 rtl/fetcher.sv | 116 +++++++++++
 1 files changed

// File: rtl/fetcher.sv
// Instruction fetch stage: probes the icache each cycle, refills from memory on a miss, emits one instruction per cycle.
// Optional feature: define FETCHER_JAL_PREDICT_EN to predict JAL / C.J targets instead of the sequential PC.
module fetcher #(
  parameter int unsigned XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  input  logic            flush,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic            fet_icache_enable,
  output logic [XLEN-1:0] fet_pc,
  input  logic            icache_ready,
  input  logic [XLEN-1:0] icache_inst,
  output logic            fet_mem_req,
  output logic [XLEN-1:0] fet_mem_addr,
  input  logic            mem_inst_ready,
  input  logic [XLEN-1:0] mem_inst_addr,
  output logic            fet_inst_valid,
  output logic [XLEN-1:0] fet_inst,
  output logic [XLEN-1:0] fet_inst_pc,
  output logic            fet_is_c,
  output logic [XLEN-1:0] fet_pred_pc
);

  typedef enum logic {FETCH, WAIT_MEM} state_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic            is_c;
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] pred_pc;

  assign fet_icache_enable = (state == FETCH) && !rst;
  assign fet_pc            = pc;

  assign is_c   = (icache_inst[1:0] != 2'b11);
  assign seq_pc = pc + (is_c ? XLEN'(2) : XLEN'(4));

`ifdef FETCHER_JAL_PREDICT_EN
  logic            is_jal;
  logic            is_cj;
  logic [20:0]     j_imm;
  logic [11:0]     cj_imm;

  assign is_jal = (icache_inst[6:0] == 7'b1101111);
  assign is_cj  = (icache_inst[15:13] == 3'b101) && (icache_inst[1:0] == 2'b01);
  assign j_imm  = {icache_inst[31], icache_inst[19:12], icache_inst[20], icache_inst[30:21], 1'b0};
  assign cj_imm = {icache_inst[12], icache_inst[8], icache_inst[10:9], icache_inst[6], icache_inst[7],
                   icache_inst[2], icache_inst[11], icache_inst[5:3], 1'b0};

  // Targets are pc-relative with sign-extended immediates; arithmetic wraps modulo 2^XLEN.
  always_comb begin
    pred_pc = seq_pc;
    if (is_jal)
      pred_pc = pc + XLEN'({{(XLEN-21){j_imm[20]}}, j_imm});
    else if (is_cj)
      pred_pc = pc + XLEN'({{(XLEN-12){cj_imm[11]}}, cj_imm});
  end
`else
  assign pred_pc = seq_pc;
`endif

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= FETCH;
      pc             <= RESET_PC;
      fet_mem_req    <= 1'b0;
      fet_mem_addr   <= '0;
      fet_inst_valid <= 1'b0;
      fet_inst       <= '0;
      fet_inst_pc    <= '0;
      fet_is_c       <= 1'b0;
      fet_pred_pc    <= '0;
    end else if (rdy) begin
      if (flush) begin
        // Redirect discards any outstanding refill; a late response no longer matches the new pc.
        pc             <= redirect_pc;
        state          <= FETCH;
        fet_mem_req    <= 1'b0;
        fet_inst_valid <= 1'b0;
      end else begin
        fet_inst_valid <= 1'b0;
        case (state)
          FETCH: begin
            if (icache_ready) begin
              if (!stall) begin
                fet_inst_valid <= 1'b1;
                fet_inst       <= icache_inst;
                fet_inst_pc    <= pc;
                fet_is_c       <= is_c;
                fet_pred_pc    <= pred_pc;
                pc             <= pred_pc;
              end
            end else begin
              fet_mem_req  <= 1'b1;
              fet_mem_addr <= pc;
              state        <= WAIT_MEM;
            end
          end
          WAIT_MEM: begin
            if (mem_inst_ready && (mem_inst_addr == pc)) begin
              fet_mem_req <= 1'b0;
              state       <= FETCH;
            end
          end
          default: state <= FETCH;
        endcase
      end
    end
  end

endmodule
